// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives Imem_A and holds the IF/ID register with a valid/ready handshake.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of clearing bits [1:0].
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES = 8,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [31:0] Imem_A,
    input  logic [31:0] Imem_RD,
    input  logic        Id_Ready,
    input  logic        Redirect,
    input  logic [31:0] Redirect_Target,
    input  logic        Halt,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC_Plus4,
    output logic        IF_Valid,
    output logic [1:0]  Fetch_State,
    output logic        Misalign
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] boot_cnt_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_pc_plus4_q;
    logic        if_valid_q;

    logic [31:0] pc_seq_d;
    logic [31:0] redirect_pc_d;
    logic        boot_done;

    assign pc_seq_d      = pc_q + 32'd4;
    assign redirect_pc_d = Redirect_Target & ~32'h0000_0003;
    assign boot_done     = (BOOT_CYCLES == 0) || (boot_cnt_q == BOOT_CYCLES - 1);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;
    assign Misalign = misalign_q;
`else
    assign Misalign = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            boot_cnt_q    <= '0;
            if_instr_q    <= NOP_INSTR;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
            if_valid_q    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (Redirect) begin
                        if_valid_q <= 1'b0;
                        if_instr_q <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (|Redirect_Target[1:0]) begin
                            misalign_q <= 1'b1;
                            state_q    <= ST_HALTED;
                        end else begin
                            pc_q <= redirect_pc_d;
                        end
`else
                        pc_q <= redirect_pc_d;
`endif
                    end else if (Halt) begin
                        state_q <= ST_HALTED;
                    end else if (!if_valid_q || Id_Ready) begin
                        if_instr_q    <= Imem_RD;
                        if_pc_q       <= pc_q;
                        if_pc_plus4_q <= pc_seq_d;
                        if_valid_q    <= 1'b1;
                        pc_q          <= pc_seq_d;
                    end
                end
                ST_HALTED: begin
                    // PC stays frozen; only drain a pending instruction to decode.
                    if (if_valid_q && Id_Ready) begin
                        if_valid_q <= 1'b0;
                        if_instr_q <= NOP_INSTR;
                    end
                end
                default: begin
                    // Unused encoding 11 falls through here and behaves as BOOT.
                    boot_cnt_q <= boot_cnt_q + 32'd1;
                    if (boot_done) begin
                        state_q <= ST_RUN;
                    end
                end
            endcase
        end
    end

    assign Imem_A      = pc_q;
    assign IF_Instr    = if_instr_q;
    assign IF_PC       = if_pc_q;
    assign IF_PC_Plus4 = if_pc_plus4_q;
    assign IF_Valid    = if_valid_q;
    assign Fetch_State = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, straight-line fetch, stall, redirect, misalign, wrap and halt.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK;
    logic        Reset;
    logic [31:0] Imem_A;
    logic [31:0] Imem_RD;
    logic        Id_Ready;
    logic        Redirect;
    logic [31:0] Redirect_Target;
    logic        Halt;
    logic [31:0] IF_Instr;
    logic [31:0] IF_PC;
    logic [31:0] IF_PC_Plus4;
    logic        IF_Valid;
    logic [1:0]  Fetch_State;
    logic        Misalign;

    int tests  = 0;
    int failed = 0;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .BOOT_CYCLES(8),
        .NOP_INSTR  (NOP)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .Imem_A         (Imem_A),
        .Imem_RD        (Imem_RD),
        .Id_Ready       (Id_Ready),
        .Redirect       (Redirect),
        .Redirect_Target(Redirect_Target),
        .Halt           (Halt),
        .IF_Instr       (IF_Instr),
        .IF_PC          (IF_PC),
        .IF_PC_Plus4    (IF_PC_Plus4),
        .IF_Valid       (IF_Valid),
        .Fetch_State    (Fetch_State),
        .Misalign       (Misalign)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Small program image; unlisted words read back as the inverted address.
    always_comb begin
        case (Imem_A)
            32'h0000_0000: Imem_RD = 32'h0050_0113;
            32'h0000_0004: Imem_RD = 32'h00c0_0193;
            32'h0000_0008: Imem_RD = 32'hff71_8393;
            32'h0000_000c: Imem_RD = 32'h0023_e233;
            32'h0000_0044: Imem_RD = 32'h0031_0133;
            default:       Imem_RD = ~Imem_A;
        endcase
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Id_Ready = 1'b1; Redirect = 1'b0; Halt = 1'b0; Redirect_Target = '0;
        tick;
        tick;
        tests++; if (IF_Valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", IF_Valid); end
        tests++; if (IF_Instr !== NOP) begin failed++; $display("FAIL reset_instr: got %h want %h", IF_Instr, NOP); end
        tests++; if (IF_PC !== 32'h0) begin failed++; $display("FAIL reset_pc: got %h want 0", IF_PC); end
        tests++; if (IF_PC_Plus4 !== 32'h0) begin failed++; $display("FAIL reset_pc4: got %h want 0", IF_PC_Plus4); end
        tests++; if (Fetch_State !== 2'b00) begin failed++; $display("FAIL reset_state: got %b want 00", Fetch_State); end
        tests++; if (Imem_A !== 32'h0) begin failed++; $display("FAIL reset_imem_a: got %h want 0", Imem_A); end
        tests++; if (Misalign !== 1'b0) begin failed++; $display("FAIL reset_misalign: got %b want 0", Misalign); end
    endtask

    task automatic test_boot;
        logic [1:0] exp_st;
        Reset = 1'b0; Redirect = 1'b1; Redirect_Target = 32'h80; Halt = 1'b1; Id_Ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) begin Redirect = 1'b0; Halt = 1'b0; end
            tick;
            exp_st = (i < 8) ? 2'b00 : 2'b01;
            tests++; if (IF_Valid !== 1'b0) begin failed++; $display("FAIL boot_valid[%0d]: got %b want 0", i, IF_Valid); end
            tests++; if (Imem_A !== 32'h0) begin failed++; $display("FAIL boot_imem_a[%0d]: got %h want 0", i, Imem_A); end
            tests++; if (Fetch_State !== exp_st) begin failed++; $display("FAIL boot_state[%0d]: got %b want %b", i, Fetch_State, exp_st); end
        end
    endtask

    task automatic test_straight_line;
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'h0050_0113; exp_instr[1] = 32'h00c0_0193; exp_instr[2] = 32'hff71_8393;
        Id_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            tests++; if (IF_Valid !== 1'b1) begin failed++; $display("FAIL line_valid[%0d]: got %b want 1", i, IF_Valid); end
            tests++; if (IF_Instr !== exp_instr[i]) begin failed++; $display("FAIL line_instr[%0d]: got %h want %h", i, IF_Instr, exp_instr[i]); end
            tests++; if (IF_PC !== 32'(4 * i)) begin failed++; $display("FAIL line_pc[%0d]: got %h want %h", i, IF_PC, 32'(4 * i)); end
            tests++; if (IF_PC_Plus4 !== 32'(4 * i + 4)) begin failed++; $display("FAIL line_pc4[%0d]: got %h want %h", i, IF_PC_Plus4, 32'(4 * i + 4)); end
            tests++; if (Imem_A !== 32'(4 * i + 4)) begin failed++; $display("FAIL line_imem_a[%0d]: got %h want %h", i, Imem_A, 32'(4 * i + 4)); end
        end
    endtask

    task automatic test_stall;
        Id_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            tests++; if (IF_PC !== 32'h8) begin failed++; $display("FAIL stall_pc[%0d]: got %h want 8", i, IF_PC); end
            tests++; if (IF_Instr !== 32'hff71_8393) begin failed++; $display("FAIL stall_instr[%0d]: got %h want ff718393", i, IF_Instr); end
            tests++; if (Imem_A !== 32'hc) begin failed++; $display("FAIL stall_imem_a[%0d]: got %h want c", i, Imem_A); end
        end
        Id_Ready = 1'b1;
        tick;
        tests++; if (IF_PC !== 32'hc) begin failed++; $display("FAIL release_pc: got %h want c", IF_PC); end
        tests++; if (IF_Instr !== 32'h0023_e233) begin failed++; $display("FAIL release_instr: got %h want 0023e233", IF_Instr); end
        tests++; if (Imem_A !== 32'h10) begin failed++; $display("FAIL release_imem_a: got %h want 10", Imem_A); end
    endtask

    task automatic test_redirect;
        Id_Ready = 1'b0; Redirect = 1'b1; Redirect_Target = 32'h44;
        tick;
        tests++; if (IF_Valid !== 1'b0) begin failed++; $display("FAIL redir_valid: got %b want 0", IF_Valid); end
        tests++; if (IF_Instr !== NOP) begin failed++; $display("FAIL redir_flush: got %h want %h", IF_Instr, NOP); end
        tests++; if (Imem_A !== 32'h44) begin failed++; $display("FAIL redir_imem_a: got %h want 44", Imem_A); end
        Redirect = 1'b0;
        tick;
        tests++; if (IF_Valid !== 1'b1) begin failed++; $display("FAIL redir_refill_valid: got %b want 1", IF_Valid); end
        tests++; if (IF_Instr !== 32'h0031_0133) begin failed++; $display("FAIL redir_instr: got %h want 00310133", IF_Instr); end
        tests++; if (IF_PC !== 32'h44) begin failed++; $display("FAIL redir_pc: got %h want 44", IF_PC); end
        tests++; if (Imem_A !== 32'h48) begin failed++; $display("FAIL redir_next_a: got %h want 48", Imem_A); end
        tick;
        tests++; if (IF_PC !== 32'h44) begin failed++; $display("FAIL redir_hold_pc: got %h want 44", IF_PC); end
        tests++; if (Imem_A !== 32'h48) begin failed++; $display("FAIL redir_hold_a: got %h want 48", Imem_A); end
    endtask

    task automatic test_misalign;
        Id_Ready = 1'b1; Redirect = 1'b1; Redirect_Target = 32'h42;
        tick;
        Redirect = 1'b0;
        tests++; if (IF_Valid !== 1'b0) begin failed++; $display("FAIL mis_valid: got %b want 0", IF_Valid); end
`ifdef FETCH_MISALIGN_TRAP_EN
        tests++; if (Misalign !== 1'b1) begin failed++; $display("FAIL mis_flag: got %b want 1", Misalign); end
        tests++; if (Fetch_State !== 2'b10) begin failed++; $display("FAIL mis_state: got %b want 10", Fetch_State); end
        tests++; if (Imem_A !== 32'h48) begin failed++; $display("FAIL mis_imem_a: got %h want 48", Imem_A); end
        tick;
        tests++; if (Misalign !== 1'b1) begin failed++; $display("FAIL mis_sticky: got %b want 1", Misalign); end
`else
        tests++; if (Misalign !== 1'b0) begin failed++; $display("FAIL mis_flag: got %b want 0", Misalign); end
        tests++; if (Fetch_State !== 2'b01) begin failed++; $display("FAIL mis_state: got %b want 01", Fetch_State); end
        tests++; if (Imem_A !== 32'h40) begin failed++; $display("FAIL mis_imem_a: got %h want 40", Imem_A); end
        tick;
        tests++; if (IF_PC !== 32'h40) begin failed++; $display("FAIL mis_pc: got %h want 40", IF_PC); end
        tests++; if (IF_Instr !== 32'hffff_ffbf) begin failed++; $display("FAIL mis_instr: got %h want ffffffbf", IF_Instr); end
`endif
    endtask

    task automatic test_wrap;
        Id_Ready = 1'b1; Redirect = 1'b1; Halt = 1'b1; Redirect_Target = 32'hffff_fffc;
        tick;
        Redirect = 1'b0; Halt = 1'b0;
        tests++; if (Fetch_State !== 2'b01) begin failed++; $display("FAIL redir_beats_halt: got %b want 01", Fetch_State); end
        tests++; if (Imem_A !== 32'hffff_fffc) begin failed++; $display("FAIL wrap_target: got %h want fffffffc", Imem_A); end
        tick;
        tests++; if (IF_PC !== 32'hffff_fffc) begin failed++; $display("FAIL wrap_pc: got %h want fffffffc", IF_PC); end
        tests++; if (IF_PC_Plus4 !== 32'h0) begin failed++; $display("FAIL wrap_pc4: got %h want 0", IF_PC_Plus4); end
        tests++; if (IF_Instr !== 32'h0000_0003) begin failed++; $display("FAIL wrap_instr: got %h want 3", IF_Instr); end
        tests++; if (Imem_A !== 32'h0) begin failed++; $display("FAIL wrap_imem_a: got %h want 0", Imem_A); end
    endtask

    task automatic test_halt;
        Id_Ready = 1'b1;
        tick;
        tests++; if (IF_Instr !== 32'h0050_0113) begin failed++; $display("FAIL halt_pre_instr: got %h want 00500113", IF_Instr); end
        Halt = 1'b1; Id_Ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            tests++; if (Fetch_State !== 2'b10) begin failed++; $display("FAIL halt_state[%0d]: got %b want 10", i, Fetch_State); end
            tests++; if (IF_Valid !== 1'b1) begin failed++; $display("FAIL halt_pending[%0d]: got %b want 1", i, IF_Valid); end
            tests++; if (Imem_A !== 32'h4) begin failed++; $display("FAIL halt_imem_a[%0d]: got %h want 4", i, Imem_A); end
        end
        Halt = 1'b0; Redirect = 1'b1; Redirect_Target = 32'h80;
        tick;
        Redirect = 1'b0;
        tests++; if (Imem_A !== 32'h4) begin failed++; $display("FAIL halt_redir_ignored: got %h want 4", Imem_A); end
        tests++; if (IF_Valid !== 1'b1) begin failed++; $display("FAIL halt_still_pending: got %b want 1", IF_Valid); end
        Id_Ready = 1'b1;
        tick;
        tests++; if (IF_Valid !== 1'b0) begin failed++; $display("FAIL halt_drain_valid: got %b want 0", IF_Valid); end
        tests++; if (IF_Instr !== NOP) begin failed++; $display("FAIL halt_drain_instr: got %h want %h", IF_Instr, NOP); end
        tests++; if (Fetch_State !== 2'b10) begin failed++; $display("FAIL halt_stays: got %b want 10", Fetch_State); end
        tick;
        tests++; if (Imem_A !== 32'h4) begin failed++; $display("FAIL halt_frozen: got %h want 4", Imem_A); end
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        tests++; if (Fetch_State !== 2'b00) begin failed++; $display("FAIL halt_reset_state: got %b want 00", Fetch_State); end
        tests++; if (Imem_A !== 32'h0) begin failed++; $display("FAIL halt_reset_a: got %h want 0", Imem_A); end
        tests++; if (Misalign !== 1'b0) begin failed++; $display("FAIL halt_reset_mis: got %b want 0", Misalign); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_boot;
        test_straight_line;
        test_stall;
        test_redirect;
        test_misalign;
        test_reset;
        test_boot;
        test_wrap;
        test_halt;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
